// File: rtl/qspi_flash_model_sync.sv
// rtl/qspi_flash_model_sync.sv - clocked QSPI flash responder (0xEB quad / 0x03 single read, XIP, backdoor load)
module qspi_flash_model_sync #(
  parameter int         ADDR_W       = 24,
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [3:0] XIP_MODE_NIB = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qspi_ck_o,
  input  logic              qspi_cs_o,
  input  logic [3:0]        qspi_io_o,
  input  logic [3:0]        qspi_io_t,
  output logic [3:0]        qspi_io_i,
  input  logic              bd_we,
  input  logic [ADDR_W-3:0] bd_waddr,
  input  logic [31:0]       bd_wdata,
  output logic              busy,
  output logic              xip_active,
  output logic              err_cmd,
  output logic              err_mode
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA_Q, S_DATA_S, S_ERR
  } state_t;

  localparam int         WORDS      = 2 ** (ADDR_W - 2);
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  logic [31:0] mem_q [WORDS];

  logic              ck_q, ck_prev_q, cs_q, cs_prev_q;
  logic [3:0]        io_q;
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [23:0]       sr_q, sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              quad_q, quad_d;
  logic              nib_q, nib_d;
  logic [2:0]        bit_q, bit_d;
  logic              xip_q, xip_d;
  logic [3:0]        io_out_q, io_out_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_mode_q, err_mode_d;

  logic        ck_rise, ck_fall, cs_fall;
  logic [23:0] sr_s1, sr_s4;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  assign ck_rise = ck_q & ~ck_prev_q;
  assign ck_fall = ~ck_q & ck_prev_q;
  assign cs_fall = ~cs_q & cs_prev_q;
  assign sr_s1   = {sr_q[22:0], io_q[0]};
  assign sr_s4   = {sr_q[19:0], io_q};
  assign rd_word = mem_q[addr_q[ADDR_W-1:2]];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (bd_we) mem_q[bd_waddr] <= bd_wdata;
  end

  // Undriven lanes read as zero so tristated IO never leaks into shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_q       <= 1'b0;
      ck_prev_q  <= 1'b0;
      cs_q       <= 1'b0;
      cs_prev_q  <= 1'b0;
      io_q       <= 4'h0;
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      sr_q       <= 24'd0;
      addr_q     <= '0;
      quad_q     <= 1'b0;
      nib_q      <= 1'b0;
      bit_q      <= 3'd7;
      xip_q      <= 1'b0;
      io_out_q   <= 4'h0;
      err_cmd_q  <= 1'b0;
      err_mode_q <= 1'b0;
    end else begin
      ck_q       <= qspi_ck_o;
      ck_prev_q  <= ck_q;
      cs_q       <= qspi_cs_o;
      cs_prev_q  <= cs_q;
      io_q       <= qspi_io_o & ~qspi_io_t;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      addr_q     <= addr_d;
      quad_q     <= quad_d;
      nib_q      <= nib_d;
      bit_q      <= bit_d;
      xip_q      <= xip_d;
      io_out_q   <= io_out_d;
      err_cmd_q  <= err_cmd_d;
      err_mode_q <= err_mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    addr_d     = addr_q;
    quad_d     = quad_q;
    nib_d      = nib_q;
    bit_d      = bit_q;
    xip_d      = xip_q;
    io_out_d   = io_out_q;
    err_cmd_d  = 1'b0;
    err_mode_d = 1'b0;

    if (state_q != S_IDLE && cs_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            cnt_d = 5'd0;
            sr_d  = 24'd0;
            nib_d = 1'b0;
            if (xip_q) begin
              quad_d  = 1'b1;
              state_d = S_ADDR;
            end else begin
              state_d = S_CMD;
            end
          end
        end
        S_CMD: begin
          if (ck_rise) begin
            sr_d  = sr_s1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = 5'd0;
              sr_d  = 24'd0;
              if (sr_s1[7:0] == 8'hEB) begin
                quad_d  = 1'b1;
                state_d = S_ADDR;
              end else if (sr_s1[7:0] == 8'h03) begin
                quad_d  = 1'b0;
                state_d = S_ADDR;
              end else begin
                err_cmd_d = 1'b1;
                state_d   = S_ERR;
              end
            end
          end
        end
        S_ADDR: begin
          if (ck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (quad_q) begin
              sr_d = sr_s4;
              if (cnt_q == 5'd5) begin
                addr_d  = sr_s4[ADDR_W-1:0];
                cnt_d   = 5'd0;
                sr_d    = 24'd0;
                state_d = S_MODE;
              end
            end else begin
              sr_d = sr_s1;
              if (cnt_q == 5'd23) begin
                addr_d  = sr_s1[ADDR_W-1:0];
                cnt_d   = 5'd0;
                bit_d   = 3'd7;
                state_d = S_DATA_S;
              end
            end
          end
        end
        S_MODE: begin
          if (ck_rise) begin
            sr_d  = sr_s4;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd1) begin
              cnt_d = 5'd0;
              nib_d = 1'b0;
              // sr_q[3:0] still holds mode[7:4] captured on the previous rise
              if (sr_q[3:0] == 4'hF || sr_q[3:0] == XIP_MODE_NIB) begin
                xip_d   = (sr_q[3:0] != 4'hF);
                state_d = (DUMMY_CYCLES == 0) ? S_DATA_Q : S_DUMMY;
              end else begin
                xip_d      = 1'b0;
                err_mode_d = 1'b1;
                state_d    = S_ERR;
              end
            end
          end
        end
        S_DUMMY: begin
          if (ck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 5'd0;
              state_d = S_DATA_Q;
            end
          end
        end
        S_DATA_Q: begin
          if (ck_fall) begin
            io_out_d = nib_q ? rd_byte[3:0] : rd_byte[7:4];
            nib_d    = ~nib_q;
            if (nib_q) addr_d = addr_q + 1'b1;
          end
        end
        S_DATA_S: begin
          if (ck_fall) begin
            io_out_d = {2'b00, rd_byte[bit_q], 1'b0};
            bit_d    = bit_q - 3'd1;
            if (bit_q == 3'd0) addr_d = addr_q + 1'b1;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign qspi_io_i  = io_out_q;
  assign busy       = (state_q != S_IDLE);
  assign xip_active = xip_q;
  assign err_cmd    = err_cmd_q;
  assign err_mode   = err_mode_q;

endmodule
